l1_wb_arbiter: RTL and testbench
================================

Name: l1_wb_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter in front of the L1 trigger submodule bus: the threshold, CE and control/timer registers.
- Master 0 is the host register path (manual/debug access); master 1 is the L1 trigger loop engine.
- Round-robin grant, grant locked while the owning master holds cyc, per-transfer ack timeout so a dead slave cannot hang the loop.

Parameters:
- ADDR_W, 22, address width of all ports
- DATA_W, 32, data width of all ports
- TIMEOUT, 255, cycles with stb high and no slave ack before forced termination (1..65535)
- TIMEOUT_DATA, 32'hFFFFFFFF, read data returned on a timed-out transfer

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge
- wb_rst_ni  in  1  reset; asynchronous, active-low
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (host) strobes
- m0_adr_i  in  ADDR_W;  m0_dat_i  in  DATA_W;  m0_sel_i  in  4
- m0_ack_o  out  1;  m0_dat_o  out  DATA_W
- m1_cyc_i, m1_stb_i, m1_we_i  in  1 each  master 1 (loop) strobes
- m1_adr_i  in  ADDR_W;  m1_dat_i  in  DATA_W;  m1_sel_i  in  4
- m1_ack_o  out  1;  m1_dat_o  out  DATA_W
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side strobes
- s_adr_o  out  ADDR_W;  s_dat_o  out  DATA_W;  s_sel_o  out  4
- s_ack_i  in  1;  s_dat_i  in  DATA_W
- grant_o  out  2  one-hot current owner: bit0 = M0, bit1 = M1; 00 when idle
- timeout_cnt_o  out  16  saturating count of timed-out transfers
- timeout_clr_i  in  1  synchronous clear of timeout_cnt_o

Behaviour:
- Reset values (async on wb_rst_ni low):
  - FSM = IDLE, grant_o = 00, last_grant = M1 (so M0 wins the first tie).
  - timeout_cnt_o = 0, timeout counter = 0.
  - s_cyc_o = s_stb_o = 0; m0_ack_o = m1_ack_o = 0.
- Request definition: req_n = mN_cyc_i & mN_stb_i.
- FSM states: IDLE, OWN_M0, OWN_M1, TO_ACK.
- IDLE:
  - Only req0 high → OWN_M0. Only req1 high → OWN_M1.
  - Both high → grant the master that is not last_grant.
  - last_grant updates on entry to OWN_x.
  - Grant is registered: the slave sees the cycle one clock after the first request cycle.
- OWN_x:
  - s_cyc_o = mx_cyc_i and s_stb_o = mx_stb_i. s_we/adr/dat/sel are muxed combinationally from master x.
  - mx_ack_o = s_ack_i and mx_dat_o = s_dat_i, both combinational. The non-owner ack is 0; the non-owner dat_o = 0.
  - Stay while mx_cyc_i = 1: lock, so multi-transfer cycles are not interrupted.
  - mx_cyc_i = 0 → IDLE. There is one dead IDLE cycle minimum between grants, so the other master gets the bus on the next arbitration when both request.
- Timeout counter:
  - Cleared on entry to OWN_x and on every s_ack_i.
  - Increments each cycle in OWN_x with s_stb_o = 1 and s_ack_i = 0.
  - Reaching TIMEOUT → TO_ACK.
- TO_ACK (exactly 1 cycle):
  - s_cyc_o = s_stb_o = 0, aborting the slave cycle.
  - Owner receives mx_ack_o = 1 with mx_dat_o = TIMEOUT_DATA.
  - timeout_cnt_o increments, saturating at 16'hFFFF.
  - Next state: OWN_x if mx_cyc_i still 1, else IDLE.
- s_ack_i while IDLE or TO_ACK: ignored, never forwarded.
- timeout_clr_i in the same cycle as a timeout increment: clear wins, result 0.
- A master dropping cyc mid-transfer without ack: the transfer is abandoned and the FSM goes to IDLE next cycle. No ack is generated.
- Async reset mid-transfer: all outputs are deasserted immediately; the slave cycle is dropped.

Test Plan:
- Single M1 write: adr 0x100, dat 0x1194; slave acks 2 cycles after s_stb_o → s_adr_o = 0x100 one clock after the request; m1_ack_o pulses once; m0_ack_o stays 0; grant_o = 10, then 00 after cyc drops.
- Simultaneous first requests from both masters after reset → M0 granted first; M1 granted after M0 drops cyc plus one IDLE cycle; the next tie goes to M0 again only after M1 has been served.
- M0 holds cyc across 3 back-to-back acked transfers while M1 requests → grant stays 01 throughout; M1 is granted only after m0_cyc_i falls.
- Slave never acks on an M1 read with TIMEOUT = 255 → s_cyc_o drops after 255 stb cycles; m1_ack_o = 1 with dat 0xFFFFFFFF; timeout_cnt_o = 1.
- Force timeout_cnt_o to 0xFFFF, then another timeout → the count stays 0xFFFF. Pulse timeout_clr_i coincident with a timeout → the count reads 0.
- Assert wb_rst_ni low in OWN_M1 mid-transfer → s_cyc_o and grant_o go to 0 without waiting for a clock edge. After release, a single M0 request is granted normally.

Source files
------------

// File: rtl/l1_wb_arbiter_if.sv
// Wishbone classic link between one master and one slave port of the L1 trigger bus.
interface l1_wb_arbiter_if #(
  parameter int unsigned ADDR_W = 22,
  parameter int unsigned DATA_W = 32
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat_w;  // master to slave
  logic [3:0]        sel;
  logic              ack;
  logic [DATA_W-1:0] dat_r;  // slave to master

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  ack, dat_r
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output ack, dat_r
  );
endinterface

// File: rtl/l1_wb_arbiter.sv
// Two-master Wishbone classic arbiter for the L1 trigger submodule bus.
// M0 = host register path, M1 = trigger loop engine. Round-robin with cyc lock and
// a per-transfer ack timeout that terminates a hung slave cycle.
module l1_wb_arbiter #(
  parameter int unsigned        ADDR_W       = 22,
  parameter int unsigned        DATA_W       = 32,
  parameter int unsigned        TIMEOUT      = 255,
  parameter logic [DATA_W-1:0]  TIMEOUT_DATA = {DATA_W{1'b1}}
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  l1_wb_arbiter_if.slave        m0_io,
  l1_wb_arbiter_if.slave        m1_io,
  l1_wb_arbiter_if.master       s_io,
  output logic [1:0]            grant_o,
  output logic [15:0]           timeout_cnt_o,
  input  logic                  timeout_clr_i
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StOwnM0 = 2'd1;
  localparam logic [1:0] StOwnM1 = 2'd2;
  localparam logic [1:0] StToAck = 2'd3;

  localparam logic [15:0] TimeoutLim = 16'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  // last_q doubles as the current owner while not idle (0 = M0, 1 = M1)
  logic        last_q, last_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [15:0] tmo_inc;

  logic req0, req1;
  logic owning, aborting, active;

  logic              own_cyc, own_stb, own_we;
  logic [ADDR_W-1:0] own_adr;
  logic [DATA_W-1:0] own_dat;
  logic [3:0]        own_sel;
  logic              ack_fwd;
  logic [DATA_W-1:0] dat_fwd;

  assign req0     = m0_io.cyc & m0_io.stb;
  assign req1     = m1_io.cyc & m1_io.stb;
  assign owning   = (state_q == StOwnM0) | (state_q == StOwnM1);
  assign aborting = (state_q == StToAck);
  assign active   = owning | aborting;
  assign tmo_inc  = tmo_q + 16'd1;

  // Select the owning master's request signals.
  always_comb begin
    if (last_q) begin
      own_cyc = m1_io.cyc;
      own_stb = m1_io.stb;
      own_we  = m1_io.we;
      own_adr = m1_io.adr;
      own_dat = m1_io.dat_w;
      own_sel = m1_io.sel;
    end else begin
      own_cyc = m0_io.cyc;
      own_stb = m0_io.stb;
      own_we  = m0_io.we;
      own_adr = m0_io.adr;
      own_dat = m0_io.dat_w;
      own_sel = m0_io.sel;
    end
  end

  // Slave side: strobes only while owned; TO_ACK aborts the slave cycle.
  assign s_io.cyc   = owning & own_cyc;
  assign s_io.stb   = owning & own_stb;
  assign s_io.we    = own_we;
  assign s_io.adr   = own_adr;
  assign s_io.dat_w = own_dat;
  assign s_io.sel   = own_sel;

  // Slave ack is ignored in IDLE and TO_ACK; TO_ACK forces a synthetic ack.
  assign ack_fwd     = aborting | (owning & s_io.ack);
  assign dat_fwd     = aborting ? TIMEOUT_DATA : s_io.dat_r;
  assign m0_io.ack   = ack_fwd & ~last_q;
  assign m1_io.ack   = ack_fwd & last_q;
  assign m0_io.dat_r = (active & ~last_q) ? dat_fwd : '0;
  assign m1_io.dat_r = (active & last_q) ? dat_fwd : '0;

  assign grant_o       = active ? {last_q, ~last_q} : 2'b00;
  assign timeout_cnt_o = tcnt_q;

  // Arbitration, lock, per-transfer timeout and timeout event counter.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      StIdle: begin
        tmo_d = '0;
        // Tie goes to the master that did not own the bus last.
        if (req0 && (!req1 || last_q)) begin
          state_d = StOwnM0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = StOwnM1;
          last_d  = 1'b1;
        end
      end
      StOwnM0, StOwnM1: begin
        if (!own_cyc) begin
          state_d = StIdle;
        end else if (s_io.ack) begin
          tmo_d = '0;
        end else if (own_stb) begin
          tmo_d = tmo_inc;
          if (tmo_inc == TimeoutLim) begin
            state_d = StToAck;
          end
        end
      end
      StToAck: begin
        tmo_d   = '0;
        tcnt_d  = (tcnt_q == 16'hFFFF) ? tcnt_q : tcnt_q + 16'd1;
        state_d = own_cyc ? (last_q ? StOwnM1 : StOwnM0) : StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (timeout_clr_i) begin
      tcnt_d = '0;
    end
  end

  // State registers; M1 recorded as last owner so M0 wins the first tie.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      tmo_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_l1_wb_arbiter.sv
// Bench for l1_wb_arbiter: directed scenarios plus a randomized phase, every cycle checked
// against a transaction-level model of owner, idle gap, pending wait and timeout count.
module tb_l1_wb_arbiter;

  localparam int unsigned AW  = 22;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 255;

  logic        clk;
  logic        rst_n;
  logic [1:0]  grant;
  logic [15:0] tcnt;
  logic        tclr;

  l1_wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
  l1_wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();
  l1_wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_bus ();

  l1_wb_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT     (TMO),
    .TIMEOUT_DATA(32'hFFFFFFFF)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .m0_io        (m0_bus),
    .m1_io        (m1_bus),
    .s_io         (s_bus),
    .grant_o      (grant),
    .timeout_cnt_o(tcnt),
    .timeout_clr_i(tclr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: owner (0 none, 1 M0, 2 M1), last served, unacked wait, event count.
  int mo_own, mo_last, mo_wait, mo_cnt;
  bit mo_to;

  // Stimulus control
  bit rnd;
  bit clr_on_ack;
  int left0, left1;  // transfers each directed master still wants
  int lat;           // slave ack latency in stb cycles; -1 never, -2 random
  int age;
  int n_sstb, n_ack0, n_ack1;
  int glog[$];
  logic [1:0] prev_grant;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    mo_own  = 0;
    mo_last = 2;
    mo_wait = 0;
    mo_cnt  = 0;
    mo_to   = 1'b0;
  endtask

  task automatic model_step();
    bit r0, r1, ocyc, ostb;
    r0   = m0_bus.cyc && m0_bus.stb;
    r1   = m1_bus.cyc && m1_bus.stb;
    ocyc = (mo_own == 1) ? m0_bus.cyc : (mo_own == 2) ? m1_bus.cyc : 1'b0;
    ostb = (mo_own == 1) ? m0_bus.stb : (mo_own == 2) ? m1_bus.stb : 1'b0;
    if (mo_to) begin
      mo_cnt  = (mo_cnt == 65535) ? 65535 : mo_cnt + 1;
      mo_to   = 1'b0;
      mo_wait = 0;
      if (!ocyc) mo_own = 0;
    end else if (mo_own == 0) begin
      if (r0 && r1) mo_own = (mo_last == 1) ? 2 : 1;
      else if (r0) mo_own = 1;
      else if (r1) mo_own = 2;
      if (mo_own != 0) mo_last = mo_own;
      mo_wait = 0;
    end else if (!ocyc) begin
      mo_own = 0;
    end else if (s_bus.ack) begin
      mo_wait = 0;
    end else if (ostb) begin
      mo_wait++;
      if (mo_wait >= int'(TMO)) begin
        mo_to   = 1'b1;
        mo_wait = 0;
      end
    end
    if (tclr) mo_cnt = 0;
  endtask

  task automatic check_outputs();
    logic        ocyc, ostb, owe;
    logic [AW-1:0] oadr;
    logic [DW-1:0] odat;
    logic [3:0]  osel;
    logic [1:0]  eg;
    bit          own_ok;
    if (mo_own == 2) begin
      ocyc = m1_bus.cyc; ostb = m1_bus.stb; owe = m1_bus.we;
      oadr = m1_bus.adr; odat = m1_bus.dat_w; osel = m1_bus.sel;
    end else begin
      ocyc = m0_bus.cyc; ostb = m0_bus.stb; owe = m0_bus.we;
      oadr = m0_bus.adr; odat = m0_bus.dat_w; osel = m0_bus.sel;
    end
    eg     = (mo_own == 1) ? 2'b01 : (mo_own == 2) ? 2'b10 : 2'b00;
    own_ok = (mo_own != 0) && !mo_to;
    chk("grant", 64'(grant), 64'(eg));
    chk("s_cyc", 64'(s_bus.cyc), 64'(own_ok && ocyc));
    chk("s_stb", 64'(s_bus.stb), 64'(own_ok && ostb));
    chk("m0_ack", 64'(m0_bus.ack), 64'((mo_own == 1) && (mo_to || s_bus.ack)));
    chk("m1_ack", 64'(m1_bus.ack), 64'((mo_own == 2) && (mo_to || s_bus.ack)));
    chk("m0_dat", 64'(m0_bus.dat_r),
        64'((mo_own != 1) ? 32'h0 : mo_to ? 32'hFFFFFFFF : s_bus.dat_r));
    chk("m1_dat", 64'(m1_bus.dat_r),
        64'((mo_own != 2) ? 32'h0 : mo_to ? 32'hFFFFFFFF : s_bus.dat_r));
    chk("tcnt", 64'(tcnt), 64'(mo_cnt));
    if (own_ok) begin
      chk("s_we", 64'(s_bus.we), 64'(owe));
      chk("s_adr", 64'(s_bus.adr), 64'(oadr));
      chk("s_dat", 64'(s_bus.dat_w), 64'(odat));
      chk("s_sel", 64'(s_bus.sel), 64'(osel));
    end
  endtask

  // One bus cycle: drive from negedge, check, advance model at posedge.
  task automatic tick();
    logic c_stb, c_ack0, c_ack1;
    if (rnd) begin
      m0_bus.cyc   = ($urandom_range(3) != 0);
      m0_bus.stb   = m0_bus.cyc & 1'($urandom_range(1));
      m0_bus.we    = 1'($urandom_range(1));
      m0_bus.adr   = AW'($urandom);
      m0_bus.dat_w = $urandom;
      m0_bus.sel   = 4'($urandom);
      m1_bus.cyc   = ($urandom_range(3) != 0);
      m1_bus.stb   = m1_bus.cyc & 1'($urandom_range(1));
      m1_bus.we    = 1'($urandom_range(1));
      m1_bus.adr   = AW'($urandom);
      m1_bus.dat_w = $urandom;
      m1_bus.sel   = 4'($urandom);
    end else begin
      m0_bus.cyc = (left0 > 0);
      m0_bus.stb = (left0 > 0);
      m1_bus.cyc = (left1 > 0);
      m1_bus.stb = (left1 > 0);
    end
    #1;
    s_bus.dat_r = $urandom;
    if (lat == -2) s_bus.ack = 1'($urandom_range(1));
    else s_bus.ack = s_bus.stb && (lat >= 0) && (age == lat);
    #1;
    if (rnd) tclr = ($urandom_range(15) == 0);
    else tclr = clr_on_ack && (m0_bus.ack || m1_bus.ack);
    check_outputs();
    c_stb  = s_bus.stb;
    c_ack0 = m0_bus.ack;
    c_ack1 = m1_bus.ack;
    if (c_stb) n_sstb++;
    if (c_ack0) n_ack0++;
    if (c_ack1) n_ack1++;
    if (grant != 2'b00 && grant != prev_grant) glog.push_back(int'(grant));
    prev_grant = grant;
    @(posedge clk);
    model_step();
    if (c_stb && s_bus.ack) age = 0;
    else if (c_stb) age++;
    else age = 0;
    if (!rnd) begin
      if (c_ack0 && left0 > 0) left0--;
      if (c_ack1 && left1 > 0) left1--;
    end
    @(negedge clk);
  endtask

  task automatic run_until_done(input string tag);
    for (int i = 0; i < 700; i++) begin
      if (left0 == 0 && left1 == 0) break;
      tick();
    end
    chk(tag, 64'(left0 == 0 && left1 == 0), 64'(1));
    tick();
    tick();
  endtask

  task automatic clear_stats();
    n_sstb = 0; n_ack0 = 0; n_ack1 = 0;
    glog.delete();
    prev_grant = 2'b00;
  endtask

  task automatic idle_inputs();
    m0_bus.cyc = 0; m0_bus.stb = 0; m0_bus.we = 0; m0_bus.adr = '0;
    m0_bus.dat_w = '0; m0_bus.sel = 4'hF;
    m1_bus.cyc = 0; m1_bus.stb = 0; m1_bus.we = 0; m1_bus.adr = '0;
    m1_bus.dat_w = '0; m1_bus.sel = 4'hF;
    s_bus.ack = 0; s_bus.dat_r = '0;
    tclr = 0;
    left0 = 0; left1 = 0; age = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_grant", 64'(grant), 64'(2'b00));
    chk("rst_s_cyc", 64'(s_bus.cyc), 64'(0));
    chk("rst_s_stb", 64'(s_bus.stb), 64'(0));
    chk("rst_acks", 64'({m1_bus.ack, m0_bus.ack}), 64'(0));
    chk("rst_tcnt", 64'(tcnt), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    rnd = 1'b0;
    clr_on_ack = 1'b0;
    lat = 0;
    idle_inputs();
    model_reset();
    clear_stats();
    @(negedge clk);
    do_reset();

    // Single M1 write, slave acks two cycles after strobe.
    clear_stats();
    lat = 2;
    m1_bus.we = 1'b1; m1_bus.adr = 22'h100; m1_bus.dat_w = 32'h1194; m1_bus.sel = 4'hF;
    left1 = 1;
    tick();
    #1;
    chk("t1_s_adr", 64'(s_bus.adr), 64'(22'h100));
    chk("t1_s_stb", 64'(s_bus.stb), 64'(1));
    chk("t1_grant", 64'(grant), 64'(2'b10));
    run_until_done("t1_done");
    chk("t1_m1_acks", 64'(n_ack1), 64'(1));
    chk("t1_m0_acks", 64'(n_ack0), 64'(0));
    chk("t1_grant_end", 64'(grant), 64'(2'b00));

    // Simultaneous first requests after reset, then another tie.
    do_reset();
    clear_stats();
    lat = 1;
    m0_bus.adr = 22'h2A0; m0_bus.dat_w = 32'hA5A5_0001; m0_bus.we = 1'b1;
    m1_bus.adr = 22'h044; m1_bus.we = 1'b0;
    left0 = 2; left1 = 2;
    run_until_done("tie_done");
    left0 = 1; left1 = 1;
    run_until_done("tie2_done");
    chk("tie_len", 64'(glog.size()), 64'(4));
    if (glog.size() == 4) begin
      chk("tie_g0", 64'(glog[0]), 64'(1));
      chk("tie_g1", 64'(glog[1]), 64'(2));
      chk("tie_g2", 64'(glog[2]), 64'(1));
      chk("tie_g3", 64'(glog[3]), 64'(2));
    end

    // M0 locks the bus for three back-to-back acked transfers while M1 waits.
    clear_stats();
    lat = 0;
    left0 = 3; left1 = 1;
    run_until_done("lock_done");
    chk("lock_m0_acks", 64'(n_ack0), 64'(3));
    chk("lock_len", 64'(glog.size()), 64'(2));
    if (glog.size() == 2) begin
      chk("lock_g0", 64'(glog[0]), 64'(1));
      chk("lock_g1", 64'(glog[1]), 64'(2));
    end

    // Slave never acks an M1 read.
    clear_stats();
    lat = -1;
    m1_bus.we = 1'b0; m1_bus.adr = 22'h3F0;
    left1 = 1;
    run_until_done("to_done");
    chk("to_stb_cycles", 64'(n_sstb), 64'(TMO));
    chk("to_m1_acks", 64'(n_ack1), 64'(1));
    chk("to_cnt", 64'(tcnt), 64'(1));

    // Saturation of the timeout event counter.
    force dut.tcnt_q = 16'hFFFF;
    mo_cnt = 65535;
    tick();
    tick();
    release dut.tcnt_q;
    tick();
    clear_stats();
    left1 = 1;
    run_until_done("sat_done");
    chk("sat_cnt", 64'(tcnt), 64'(16'hFFFF));

    // Clear coincident with a timeout increment.
    clear_stats();
    clr_on_ack = 1'b1;
    left1 = 1;
    run_until_done("clr_done");
    clr_on_ack = 1'b0;
    tclr = 1'b0;
    chk("clr_cnt", 64'(tcnt), 64'(0));

    // Asynchronous reset in the middle of an M1 transfer.
    clear_stats();
    left1 = 1;
    repeat (3) tick();
    chk("arst_pre_cyc", 64'(s_bus.cyc), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("arst_s_cyc", 64'(s_bus.cyc), 64'(0));
    chk("arst_grant", 64'(grant), 64'(2'b00));
    chk("arst_m1_ack", 64'(m1_bus.ack), 64'(0));
    idle_inputs();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    lat = 1;
    m0_bus.adr = 22'h011; m0_bus.we = 1'b0;
    left0 = 1;
    run_until_done("arst_m0_done");
    chk("arst_m0_acks", 64'(n_ack0), 64'(1));
    chk("arst_len", 64'(glog.size()), 64'(1));
    if (glog.size() == 1) chk("arst_g0", 64'(glog[0]), 64'(1));

    // Randomized traffic against the model.
    rnd = 1'b1;
    lat = -2;
    repeat (2000) tick();
    rnd = 1'b0;
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
